// File: rtl/ysyx_23060077_wbu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060077_wbu
// Brief   : Write-back unit. Accepts execute-stage results, waits for load
//           data where needed, extracts/extends the loaded lane and drives a
//           single register-file write plus a retire pulse per instruction.
// Rev     : 1.0  initial release
// ============================================================================
module ysyx_23060077_wbu #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_rd_en,
  input  logic [REG_WIDTH-1:0]  in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_en,
  output logic [REG_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  commit,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_MEM = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  logic [1:0]            state_q,     state_d;
  logic                  rd_en_lat_q, rd_en_lat_d;
  logic [REG_WIDTH-1:0]  rd_addr_q,   rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic [2:0]            ltype_q,     ltype_d;
  logic [1:0]            addr_lo_q,   addr_lo_d;
  logic                  err_q,       err_d;

  logic                  w_hs;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_err;

  assign in_ready = (state_q != S_WAIT_MEM);
  assign w_hs     = in_valid & in_ready;

  assign busy     = (state_q == S_WAIT_MEM);
  assign commit   = (state_q == S_WRITE);
  // A retired write to x0 still commits but never touches the register file.
  assign rd_en    = (state_q == S_WRITE) & rd_en_lat_q & (|rd_addr_q);
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

  // Lane selection uses the offset captured at acceptance, not the live input.
  assign w_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
  assign w_half = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];

  // Extract and extend the load lane; flag misaligned or undefined accesses.
  always_comb begin
    w_load_data = '0;
    w_load_err  = 1'b0;
    case (ltype_q)
      LT_LB:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LT_LBU: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      LT_LH: begin
        w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        w_load_err  = addr_lo_q[0];
      end
      LT_LHU: begin
        w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
        w_load_err  = addr_lo_q[0];
      end
      LT_LW: begin
        w_load_data = mem_rdata;
        w_load_err  = |addr_lo_q;
      end
      default: begin
        w_load_data = '0;
        w_load_err  = 1'b1;
      end
    endcase
  end

  // Next-state logic: accept offers in IDLE/WRITE, complete loads in WAIT_MEM.
  always_comb begin
    state_d     = state_q;
    rd_en_lat_d = rd_en_lat_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    ltype_d     = ltype_q;
    addr_lo_d   = addr_lo_q;
    err_d       = err_q;
    case (state_q)
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d   = S_WRITE;
          rd_data_d = w_load_data;
          err_d     = err_q | w_load_err;
        end
      end
      default: begin
        // A response with no load outstanding is a protocol violation.
        state_d = S_IDLE;
        if (mem_rvalid) begin
          err_d = 1'b1;
        end
        if (w_hs) begin
          rd_en_lat_d = in_rd_en;
          rd_addr_d   = in_rd_addr;
          if (in_is_load) begin
            state_d   = S_WAIT_MEM;
            ltype_d   = in_load_type;
            addr_lo_d = in_addr_lo;
          end else begin
            state_d   = S_WRITE;
            rd_data_d = in_alu_result;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_en_lat_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      ltype_q     <= 3'b000;
      addr_lo_q   <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_lat_q <= rd_en_lat_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      ltype_q     <= ltype_d;
      addr_lo_q   <= addr_lo_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire
